bcd_xs3_serial_conv: RTL and testbench



---
 rtl/bcd_xs3_pkg.sv | 20 ++
 rtl/xs3_digit_conv.sv | 31 +++
 rtl/bcd_xs3_serial_conv.sv | 132 +++++++++++++
 tb/tb_bcd_xs3_serial_conv.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the digit-serial BCD <-> Excess-3 converter.
// Used by xs3_digit_conv and bcd_xs3_serial_conv.
package bcd_xs3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam logic [3:0] XS3_OFFSET   = 4'd3;
  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] XS3_MIN      = 4'd3;
  localparam logic [3:0] XS3_MAX      = 4'd12;
  localparam logic [3:0] ILLEGAL_CODE = 4'hF;

  localparam logic MODE_BCD2XS3 = 1'b0;
  localparam logic MODE_XS32BCD = 1'b1;

endpackage

// File: rtl/xs3_digit_conv.sv
// Combinational single-digit BCD <-> Excess-3 converter with illegal-code flag.
// Illegal digits map to ILLEGAL_CODE.
module xs3_digit_conv
  import bcd_xs3_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_mode,
  output logic [3:0] o_result,
  output logic       o_illegal
);

  always_comb begin
    o_result  = ILLEGAL_CODE;
    o_illegal = 1'b1;
    unique case (i_mode)
      MODE_BCD2XS3: begin
        if (i_digit <= BCD_MAX) begin
          o_result  = i_digit + XS3_OFFSET;
          o_illegal = 1'b0;
        end
      end
      MODE_XS32BCD: begin
        if (i_digit >= XS3_MIN && i_digit <= XS3_MAX) begin
          o_result  = i_digit - XS3_OFFSET;
          o_illegal = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// Digit-serial N-digit BCD <-> Excess-3 converter, LSD first, valid/ready.
// Optional per-digit error mask port: define BCD_XS3_ERR_MASK_EN.
module bcd_xs3_serial_conv
  import bcd_xs3_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_data,
  output logic                    out_err
`ifdef BCD_XS3_ERR_MASK_EN
  ,
  output logic [NUM_DIGITS-1:0]   out_err_mask
`endif
);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [4*NUM_DIGITS-1:0] r_result;
  logic                    r_mode;
  logic [3:0]              w_digit;
  logic [3:0]              w_res;
  logic                    w_ill;
  logic                    w_last;

`ifdef BCD_XS3_ERR_MASK_EN
  logic [NUM_DIGITS-1:0]   r_err_mask;
  assign out_err      = |r_err_mask;
  assign out_err_mask = r_err_mask;
`else
  logic                    r_err;
  assign out_err = r_err;
`endif

  assign out_data = r_result;
  assign w_last   = (r_cnt == CNT_W'(NUM_DIGITS - 1));

  always_comb begin
    w_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_cnt == CNT_W'(i)) w_digit = r_data[i*4 +: 4];
    end
  end

  xs3_digit_conv u_conv (
    .i_digit   (w_digit),
    .i_mode    (r_mode),
    .o_result  (w_res),
    .o_illegal (w_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = CONV;
      end
      CONV: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_data   <= '0;
      r_mode   <= 1'b0;
      r_result <= '0;
`ifdef BCD_XS3_ERR_MASK_EN
      r_err_mask <= '0;
`else
      r_err      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data   <= in_data;
            r_mode   <= in_mode;
            r_result <= '0;
            r_cnt    <= '0;
`ifdef BCD_XS3_ERR_MASK_EN
            r_err_mask <= '0;
`else
            r_err      <= 1'b0;
`endif
          end
        end
        CONV: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_result[i*4 +: 4] <= w_res;
`ifdef BCD_XS3_ERR_MASK_EN
              r_err_mask[i]      <= w_ill;
`endif
            end
          end
`ifndef BCD_XS3_ERR_MASK_EN
          if (w_ill) r_err <= 1'b1;
`endif
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Self-checking bench for bcd_xs3_serial_conv (NUM_DIGITS=4).
// Directed plus random words checked against a per-digit arithmetic model.
module tb_bcd_xs3_serial_conv;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [4*N-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [4*N-1:0] out_data;
  logic          out_err;
`ifdef BCD_XS3_ERR_MASK_EN
  logic [N-1:0]  out_err_mask;
`endif

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_data;
  logic [3:0]  exp_mask;

  always #5 clk = ~clk;

  bcd_xs3_serial_conv #(.NUM_DIGITS(N), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef BCD_XS3_ERR_MASK_EN
    ,
    .out_err_mask (out_err_mask)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [15:0] d, input logic m,
                                output logic [15:0] r,
                                output logic [3:0] msk);
    r   = '0;
    msk = '0;
    for (int i = 0; i < N; i++) begin
      int v;
      int o;
      bit ill;
      v = int'(d[i*4 +: 4]);
      if (m == 1'b0) begin
        ill = (v > 9);
        o   = v + 3;
      end else begin
        ill = (v < 3) || (v > 12);
        o   = v - 3;
      end
      r[i*4 +: 4] = ill ? 4'hF : 4'(o);
      msk[i]      = ill;
    end
  endfunction

  task automatic start_word(input logic [15:0] d, input logic m,
                            input string tag);
    int lat;
    model(d, m, exp_data, exp_mask);
    @(negedge clk);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_mode  = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_data));
    chk({tag, "_err"}, 32'(out_err), 32'(|exp_mask));
`ifdef BCD_XS3_ERR_MASK_EN
    chk({tag, "_mask"}, 32'(out_err_mask), 32'(exp_mask));
`endif
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ov_low"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic full_word(input logic [15:0] d, input logic m,
                           input string tag);
    start_word(d, m, tag);
    check_result(tag);
    consume(tag);
  endtask

  initial begin
    logic [15:0] words [2];
    logic        modes [2];
    logic [15:0] bexp  [2];
    logic [3:0]  bmsk  [2];
    int          acc_cyc [2];
    int          nacc;
    int          nres;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    full_word(16'h1234, 1'b0, "d1234");
    full_word(16'h9090, 1'b0, "d9090");
    full_word(16'h3C3C, 1'b1, "d3C3C");
    full_word(16'h12A4, 1'b0, "d12A4");
    full_word(16'h0D33, 1'b1, "d0D33");

    start_word(16'h2468, 1'b0, "bp");
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 2);
      in_data  = 16'h1111;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'(exp_data));
      chk("bp_hold_err", 32'(out_err), 32'(|exp_mask));
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_ghost", 32'(out_valid), 32'd0);
    chk("bp_idle_hold", 32'(out_data), 32'(exp_data));

    start_word(16'h0000, 1'b0, "pre");
    consume("pre");
    @(negedge clk);
    in_data  = 16'h5678;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    chk("mid_rst_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    full_word(16'h0000, 1'b0, "post_rst");

    for (int k = 0; k < 16; k++) begin
      full_word(16'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
    end

    words[0] = 16'($urandom);
    modes[0] = 1'($urandom);
    words[1] = 16'($urandom);
    modes[1] = 1'($urandom);
    for (int i = 0; i < 2; i++) model(words[i], modes[i], bexp[i], bmsk[i]);
    nacc = 0;
    nres = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nres < 2; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        chk($sformatf("b2b%0d_data", nres), 32'(out_data), 32'(bexp[nres]));
        chk($sformatf("b2b%0d_err", nres), 32'(out_err), 32'(|bmsk[nres]));
        nres++;
      end
      if (nacc < 2) begin
        in_valid = 1'b1;
        in_data  = words[nacc];
        in_mode  = modes[nacc];
        if (in_ready) begin
          acc_cyc[nacc] = cyc;
          nacc++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", 32'(nres), 32'd2);
    chk("b2b_accepts", 32'(nacc), 32'd2);
    if (nacc == 2)
      chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(N + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
